ram_color_serializer: RTL and testbench
=======================================

// Module: ram_color_serializer
// PURPOSE
//  Reads a run of 12-bit program words from the program RAM and unpacks each into six
//  2-bit colour nits, MSB nit first, for the colour transmitter that writes RGBY-ROM
//  cartridges. It is the inverse of the cartridge-to-RAM packing path.
//  Drives the RAM read port and issues nits on a valid/ready handshake, with no gap
//  between consecutive words.
// PARAMETERS
//  WORD_WIDTH  12  RAM word width; must be a multiple of NIT_WIDTH
//  NIT_WIDTH   2   bits per colour nit
//  ADDR_WIDTH  8   RAM address width; addresses wrap modulo 2**ADDR_WIDTH
//  (derived) NITS_PER_WORD = WORD_WIDTH/NIT_WIDTH = 6
// PORTS
//  clk           in   1           single system clock, rising edge
//  reset         in   1           asynchronous, active-low
//  start         in   1           1-cycle request; sampled only while idle
//  startAddress  in   ADDR_WIDTH  first RAM word to send
//  wordCount     in   ADDR_WIDTH+1  words to send, 0..256; 0 = no-op
//  readAddress   out  ADDR_WIDTH  RAM raddr; registered; RAM dout valid 1 clk after sample
//  readData      in   WORD_WIDTH  RAM dout
//  color         out  NIT_WIDTH   current nit (0=R,1=G,2=B,3=Y)
//  colorValid    out  1           nit on color is valid
//  colorReady    in   1           transmitter accepts nit; handshake = colorValid&colorReady
//  busy          out  1           high from the start-accept edge until the done pulse
//  done          out  1           1-cycle pulse at the end of each run
// BEHAVIOUR
//  Reset (async, low): state=IDLE. readAddress=0, color=0, colorValid=0, busy=0, done=0.
//    Shift register, nit counter and remaining count cleared. A run in flight is abandoned.
//  FSM states: IDLE, READ, LOAD, SHIFT, DONE.
//  IDLE: start&&wordCount!=0 -> readAddress<=startAddress, remaining<=wordCount, busy<=1, ->READ.
//    start&&wordCount==0 -> ->DONE (done pulse); no colorValid, no read.
//  READ (1 clk): RAM samples readAddress; ->LOAD.
//  LOAD (1 clk): shiftReg<=readData; nitCnt<=0; remaining<=remaining-1;
//    readAddress<=readAddress+1 (prefetch); ->SHIFT.
//    First colorValid is visible after the 3rd rising edge, counting the start-sampling edge.
//  SHIFT: colorValid=1; color=shiftReg[WORD_WIDTH-1 -: NIT_WIDTH].
//    On handshake with nitCnt<5: shiftReg<<=NIT_WIDTH, nitCnt++.
//    On handshake with nitCnt==5 and remaining!=0: shiftReg<=readData (prefetched word),
//      nitCnt<=0, remaining--, readAddress++. Stay in SHIFT, no bubble.
//    On handshake with nitCnt==5 and remaining==0: colorValid<=0; ->DONE.
//    No handshake: color, colorValid and the shift register hold, so color is stable under stall.
//  DONE (1 clk): done=1, busy<=0; ->IDLE. A start in DONE is ignored.
//  start while busy is ignored. colorReady outside SHIFT is ignored.
//  readAddress increments modulo 2**ADDR_WIDTH (0xFF -> 0x00). wordCount=256 sends all of RAM.
//  The prefetch is always valid: readAddress is stable for at least 6 clk before reuse.
//  RAM write/read contention is the caller's responsibility; this block does not arbitrate.
//  Throughput with colorReady held high: 1 nit/clk. A run of N words takes 6N+3 clk
//    from the start-sampling edge to done.
// STRUCTURE
//  Shared package rgby_pkg: NIT_WIDTH, WORD_WIDTH, NITS_PER_WORD, colour constants
//    COLOR_RED=0, COLOR_GREEN=1, COLOR_BLUE=2, COLOR_YELLOW=3, serializer state enum.
//  Sub-module nit_unpacker: shift register plus nit counter. Ports: load, loadData, advance,
//    nit, lastNit. The top level owns the FSM, the address and remaining counters, and
//    the handshake.
// TESTING
//  1 RAM[0x10]=0x1B6, start addr=0x10 cnt=1, ready=1 -> color 0,1,2,3,1,2 on 6 consecutive clk;
//    done one clk after the last handshake; busy low after done.
//  2 RAM[0xFE..0x01]=0xFFF,0x000,0x555; start addr=0xFE cnt=3, ready=1 -> readAddress goes
//    FE,FF,00; 18 nits with no bubble; done at clk 21.
//  3 cnt=2, colorReady random at 30% duty -> nits match the reference unpack; color/colorValid
//    never change while valid&&!ready.
//  4 cnt=0 start -> done pulse, colorValid never high. start mid-run -> no effect on the stream.
//  5 assert reset low in SHIFT at nit 3 -> all outputs 0 immediately (async).
//    After release, a new start with addr=0x20 cnt=1 -> correct 6 nits.
//  6 cnt=256 addr=0x00, ready=1 -> 1536 nits; readAddress wraps; done at clk 1539.

Source files
------------

// File: rtl/rgby_pkg.sv
// Shared definitions for the RGBY colour path.
//   NIT_WIDTH / WORD_WIDTH / NITS_PER_WORD : default geometry of a program word.
//   COLOR_* : nit encodings driven to the colour transmitter.
//   ser_state_e : serializer FSM states.
package rgby_pkg;

  localparam int NIT_WIDTH     = 2;
  localparam int WORD_WIDTH    = 12;
  localparam int NITS_PER_WORD = WORD_WIDTH / NIT_WIDTH;

  localparam logic [NIT_WIDTH-1:0] COLOR_RED    = 2'd0;
  localparam logic [NIT_WIDTH-1:0] COLOR_GREEN  = 2'd1;
  localparam logic [NIT_WIDTH-1:0] COLOR_BLUE   = 2'd2;
  localparam logic [NIT_WIDTH-1:0] COLOR_YELLOW = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } ser_state_e;

endpackage

// File: rtl/nit_unpacker.sv
// Shift register plus nit counter that splits one RAM word into colour nits,
// most significant nit first.
//   clk, reset : clock, asynchronous active-low reset
//   load       : capture loadData and restart the nit count (has priority)
//   loadData   : word to unpack
//   advance    : shift to the next nit
//   nit        : current nit (top NIT_WIDTH bits of the shift register)
//   lastNit    : current nit is the final nit of the word
module nit_unpacker
  import rgby_pkg::*;
#(
  parameter int WORD_WIDTH = rgby_pkg::WORD_WIDTH,
  parameter int NIT_WIDTH  = rgby_pkg::NIT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [WORD_WIDTH-1:0] loadData,
  input  logic                  advance,
  output logic [NIT_WIDTH-1:0]  nit,
  output logic                  lastNit
);

  localparam int NPW   = WORD_WIDTH / NIT_WIDTH;
  localparam int CNT_W = (NPW > 1) ? $clog2(NPW) : 1;

  logic [WORD_WIDTH-1:0] shiftReg_q, shiftReg_d;
  logic [CNT_W-1:0]      nitCnt_q, nitCnt_d;

  always_comb begin
    shiftReg_d = shiftReg_q;
    nitCnt_d   = nitCnt_q;
    if (load) begin
      shiftReg_d = loadData;
      nitCnt_d   = '0;
    end else if (advance) begin
      shiftReg_d = shiftReg_q << NIT_WIDTH;
      nitCnt_d   = nitCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shiftReg_q <= '0;
      nitCnt_q   <= '0;
    end else begin
      shiftReg_q <= shiftReg_d;
      nitCnt_q   <= nitCnt_d;
    end
  end

  assign nit     = shiftReg_q[WORD_WIDTH-1 -: NIT_WIDTH];
  assign lastNit = (nitCnt_q == CNT_W'(NPW - 1));

endmodule

// File: rtl/ram_color_serializer.sv
// Reads a run of program words from a synchronous-read RAM and streams each
// one out as colour nits (MSB nit first) on a valid/ready handshake.
//   clk, reset           : clock, asynchronous active-low reset
//   start                : one-cycle run request, sampled only in IDLE
//   startAddress         : first RAM word of the run
//   wordCount            : number of words (0 = no-op, up to 2**ADDR_WIDTH)
//   readAddress          : registered RAM read address
//   readData             : RAM output, valid one clock after the address is sampled
//   color, colorValid    : nit stream towards the transmitter
//   colorReady           : transmitter accepts the current nit
//   busy                 : run in progress (start accepted until done)
//   done                 : one-cycle pulse at the end of every run
module ram_color_serializer
  import rgby_pkg::*;
#(
  parameter int WORD_WIDTH = rgby_pkg::WORD_WIDTH,
  parameter int NIT_WIDTH  = rgby_pkg::NIT_WIDTH,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] startAddress,
  input  logic [ADDR_WIDTH:0]   wordCount,
  output logic [ADDR_WIDTH-1:0] readAddress,
  input  logic [WORD_WIDTH-1:0] readData,
  output logic [NIT_WIDTH-1:0]  color,
  output logic                  colorValid,
  input  logic                  colorReady,
  output logic                  busy,
  output logic                  done
);

  ser_state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] readAddress_q, readAddress_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  busy_q, busy_d;

  logic                 handshake;
  logic                 fetch;
  logic                 advance;
  logic [NIT_WIDTH-1:0] nit;
  logic                 lastNit;

  nit_unpacker #(
    .WORD_WIDTH (WORD_WIDTH),
    .NIT_WIDTH  (NIT_WIDTH)
  ) u_unpacker (
    .clk      (clk),
    .reset    (reset),
    .load     (fetch),
    .loadData (readData),
    .advance  (advance),
    .nit      (nit),
    .lastNit  (lastNit)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (wordCount != '0) ? ST_READ : ST_DONE;
        end
      end
      ST_READ:  state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (handshake && lastNit && (remaining_q == '0)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    colorValid = (state_q == ST_SHIFT);
    color      = colorValid ? nit : NIT_WIDTH'(COLOR_RED);
    done       = (state_q == ST_DONE);
  end

  assign handshake = colorValid && colorReady;

  // The next word was prefetched while the current one was shifting, so the
  // last nit of a word can hand straight over to readData without a bubble.
  // The same fetch step serves the initial load in LOAD.
  always_comb begin
    fetch         = (state_q == ST_LOAD) ||
                    (handshake && lastNit && (remaining_q != '0));
    advance       = handshake && !lastNit;
    readAddress_d = readAddress_q;
    remaining_d   = remaining_q;
    busy_d        = busy_q;
    if ((state_q == ST_IDLE) && start && (wordCount != '0)) begin
      readAddress_d = startAddress;
      remaining_d   = wordCount;
      busy_d        = 1'b1;
    end
    if (fetch) begin
      readAddress_d = readAddress_q + ADDR_WIDTH'(1);
      remaining_d   = remaining_q - (ADDR_WIDTH + 1)'(1);
    end
    if (state_q == ST_DONE) begin
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      readAddress_q <= '0;
      remaining_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      readAddress_q <= readAddress_d;
      remaining_q   <= remaining_d;
      busy_q        <= busy_d;
    end
  end

  assign readAddress = readAddress_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_ram_color_serializer.sv
module tb_ram_color_serializer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  startAddress;
  logic [8:0]  wordCount;
  logic [7:0]  readAddress;
  logic [11:0] readData;
  logic [1:0]  color;
  logic        colorValid;
  logic        colorReady;
  logic        busy;
  logic        done;

  logic [11:0] mem [0:255];
  logic [1:0]  exp_q [$];

  int n_checks = 0;
  int n_fail   = 0;
  int duty     = 100;

  ram_color_serializer dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .startAddress (startAddress),
    .wordCount    (wordCount),
    .readAddress  (readAddress),
    .readData     (readData),
    .color        (color),
    .colorValid   (colorValid),
    .colorReady   (colorReady),
    .busy         (busy),
    .done         (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read program RAM
  always_ff @(posedge clk) readData <= mem[readAddress];

  // Transmitter ready, changed just after each rising edge
  initial begin
    colorReady = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      colorReady = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
    end
  end

  // Scoreboard monitor: a nit presented with ready high is accepted at the
  // next rising edge, so it is popped and compared here on the falling edge.
  logic       stall_prev = 1'b0;
  logic [1:0] stall_color;
  logic [1:0] e_nit;
  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        n_checks++;
        if (colorValid !== 1'b1 || color !== stall_color) begin
          n_fail++;
          $display("FAIL stall_hold: valid=%b color=%0d, required valid=1 color=%0d",
                   colorValid, color, stall_color);
        end
      end
      if (colorValid === 1'b1 && colorReady === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_nit: color=%0d accepted, no nit expected", color);
        end else begin
          e_nit = exp_q.pop_front();
          if (color !== e_nit) begin
            n_fail++;
            $display("FAIL nit_value: color=%0d, required %0d", color, e_nit);
          end
        end
      end
      stall_prev  = (colorValid === 1'b1) && (colorReady !== 1'b1);
      stall_color = color;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference unpack: word k of the run, nits taken MSB first
  task automatic push_expected(input logic [7:0] a, input int n);
    logic [7:0]  ad;
    logic [11:0] w;
    for (int k = 0; k < n; k++) begin
      ad = a + 8'(k);
      w  = mem[ad];
      for (int j = 0; j < 6; j++) exp_q.push_back(w[11-2*j -: 2]);
    end
  endtask

  // Called on a falling edge; returns on the falling edge right after the
  // start-sampling edge (cycle 1).
  task automatic launch(input logic [7:0] a, input logic [8:0] n);
    startAddress = a;
    wordCount    = n;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic wait_done(input int cyc0, input int budget, output int done_cyc,
                           output int first_vld, output int gaps);
    int cyc;
    cyc       = cyc0;
    done_cyc  = -1;
    first_vld = -1;
    gaps      = 0;
    while (cyc <= budget) begin
      if (colorValid === 1'b1 && first_vld < 0) first_vld = cyc;
      if (done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      if (first_vld >= 0 && colorValid !== 1'b1) gaps++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    startAddress = '0;
    wordCount = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (readAddress !== 8'h00 || color !== 2'd0 || colorValid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: addr=%0h color=%0d valid=%b busy=%b done=%b, required all 0",
               readAddress, color, colorValid, busy, done);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int dc, fv, gp;
    mem[8'h10] = 12'h1B6;
    exp_q.push_back(2'd0); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    exp_q.push_back(2'd3); exp_q.push_back(2'd1); exp_q.push_back(2'd2);
    launch(8'h10, 9'd1);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy: busy=%b, required 1", busy);
    end
    wait_done(1, 50, dc, fv, gp);
    n_checks++;
    if (fv !== 3) begin n_fail++; $display("FAIL single_first_valid: cycle %0d, required 3", fv); end
    n_checks++;
    if (dc !== 9) begin n_fail++; $display("FAIL single_done: cycle %0d, required 9", dc); end
    n_checks++;
    if (gp !== 0) begin n_fail++; $display("FAIL single_bubbles: %0d, required 0", gp); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after_done: busy=%b done=%b, required 0 0", busy, done);
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL single_drain: %0d nits left, required 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int dc, fv, gp;
    mem[8'hFE] = 12'hFFF;
    mem[8'hFF] = 12'h000;
    mem[8'h00] = 12'h555;
    push_expected(8'hFE, 3);
    launch(8'hFE, 9'd3);
    n_checks++;
    if (readAddress !== 8'hFE) begin n_fail++; $display("FAIL wrap_addr0: %0h, required fe", readAddress); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (readAddress !== 8'hFF) begin n_fail++; $display("FAIL wrap_addr1: %0h, required ff", readAddress); end
    repeat (6) @(negedge clk);
    n_checks++;
    if (readAddress !== 8'h00) begin n_fail++; $display("FAIL wrap_addr2: %0h, required 00", readAddress); end
    wait_done(9, 60, dc, fv, gp);
    n_checks++;
    if (dc !== 21) begin n_fail++; $display("FAIL wrap_done: cycle %0d, required 21", dc); end
    n_checks++;
    if (gp !== 0) begin n_fail++; $display("FAIL wrap_bubbles: %0d, required 0", gp); end
    @(negedge clk);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL wrap_drain: %0d nits left, required 0", exp_q.size());
    end
  endtask

  task automatic test_random_ready();
    int dc, fv, gp;
    mem[8'h40] = 12'($urandom);
    mem[8'h41] = 12'($urandom);
    push_expected(8'h40, 2);
    duty = 30;
    launch(8'h40, 9'd2);
    wait_done(1, 2000, dc, fv, gp);
    duty = 100;
    n_checks++;
    if (dc < 0) begin n_fail++; $display("FAIL rand_done: no done within budget, required done"); end
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rand_drain: %0d nits left, required 0", exp_q.size());
    end
  endtask

  task automatic test_zero_and_ignored_start();
    int dc, fv, gp;
    launch(8'h60, 9'd0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || colorValid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: done=%b busy=%b valid=%b, required 1 0 0", done, busy, colorValid);
    end
    // start while DONE is showing must be ignored
    mem[8'h61] = 12'hABC;
    launch(8'h61, 9'd1);
    repeat (4) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || colorValid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_in_done: busy=%b valid=%b done=%b, required 0 0 0", busy, colorValid, done);
    end
    // start during a run must not disturb it
    mem[8'h30] = 12'h9C3;
    mem[8'h80] = 12'h0F0;
    push_expected(8'h30, 1);
    launch(8'h30, 9'd1);
    repeat (3) @(negedge clk);
    startAddress = 8'h80;
    wordCount    = 9'd5;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, 60, dc, fv, gp);
    n_checks++;
    if (dc !== 9) begin n_fail++; $display("FAIL midrun_done: cycle %0d, required 9", dc); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL midrun_after: busy=%b left=%0d, required 0 0", busy, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    int dc, fv, gp;
    mem[8'h50] = 12'hE4E;
    push_expected(8'h50, 1);
    launch(8'h50, 9'd1);
    repeat (5) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (readAddress !== 8'h00 || color !== 2'd0 || colorValid !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: addr=%0h color=%0d valid=%b busy=%b done=%b, required all 0",
               readAddress, color, colorValid, busy, done);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem[8'h20] = 12'h2D7;
    push_expected(8'h20, 1);
    launch(8'h20, 9'd1);
    wait_done(1, 50, dc, fv, gp);
    n_checks++;
    if (dc !== 9) begin n_fail++; $display("FAIL post_reset_done: cycle %0d, required 9", dc); end
    @(negedge clk);
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL post_reset_drain: %0d nits left, required 0", exp_q.size());
    end
  endtask

  task automatic test_full_ram();
    int dc, fv, gp;
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
    push_expected(8'h00, 256);
    launch(8'h00, 9'd256);
    wait_done(1, 2000, dc, fv, gp);
    n_checks++;
    if (fv !== 3) begin n_fail++; $display("FAIL full_first_valid: cycle %0d, required 3", fv); end
    n_checks++;
    if (dc !== 1539) begin n_fail++; $display("FAIL full_done: cycle %0d, required 1539", dc); end
    n_checks++;
    if (gp !== 0) begin n_fail++; $display("FAIL full_bubbles: %0d, required 0", gp); end
    @(negedge clk);
    n_checks++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain: left=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_random_ready();
    test_zero_and_ignored_start();
    test_async_reset();
    test_full_ram();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
